// File: rtl/cbus_arbiter_pkg.sv
// Common control-bus types shared by the fetch, load/store and MMU-side blocks.
// Holds the request/response structs and the arbiter owner/state encodings.
// Types only; no logic, no latency.
package cbus_arbiter_pkg;

    // Request toward the shared translation/memory port.
    typedef struct packed {
        logic        valid;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cbus_req_t;

    // Response from the shared port; ready marks a beat, last marks the final beat.
    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

    // Owner encoding as seen on the arbiter's owner output.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } cbus_owner_e;

    // Arbiter state encoding; each state equals the owner value it reports.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } cbus_arb_state_e;

endpackage

// File: rtl/cbus_arbiter.sv
// Two-way arbiter (instruction fetch vs load/store) in front of the shared MMU port.
// Latency: one cycle from a valid request in IDLE to it appearing on oreq; one idle cycle after each completion.
// Backpressure: a non-owner request simply waits unanswered; a grant ends only on oresp.ready && oresp.last.
module cbus_arbiter
    import cbus_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  cbus_req_t  ireq,
    output cbus_resp_t iresp,
    input  cbus_req_t  dreq,
    output cbus_resp_t dresp,
    output cbus_req_t  oreq,
    input  cbus_resp_t oresp,
    output logic [1:0] owner
);

    // Counter wide enough to hold STARVE_LIMIT itself (saturating value).
    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    cbus_arb_state_e  state;
    logic [CNT_W-1:0] starve_cnt;
    logic             starved;
    logic             done;

    // Data normally wins, but once it has taken STARVE_LIMIT grants in a row
    // while fetch was waiting, fetch is served next.
    assign starved = ireq.valid && dreq.valid && (starve_cnt == CNT_MAX);
    assign done    = oresp.ready && oresp.last;

    // Grant state machine and starvation counter; completion always passes through IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dreq.valid && !starved) begin
                        state <= GNT_D;
                        if (ireq.valid && (starve_cnt != CNT_MAX)) begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end
                    end else if (ireq.valid) begin
                        state      <= GNT_I;
                        starve_cnt <= '0;
                    end
                end
                GNT_I, GNT_D: begin
                    if (done) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Route the owner's request out and the shared response back to the owner only.
    always_comb begin
        oreq  = '0;
        iresp = '0;
        dresp = '0;
        case (state)
            GNT_I: begin
                oreq  = ireq;
                iresp = oresp;
            end
            GNT_D: begin
                oreq  = dreq;
                dresp = oresp;
            end
            default: begin
            end
        endcase
    end

    assign owner = state;

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed self-checking bench for cbus_arbiter.
// Inputs change 1 time unit after the rising edge; outputs are checked before the next edge.
// Expected values are hand-derived constants.
module tb_cbus_arbiter;
    import cbus_arbiter_pkg::*;

    logic       clk;
    logic       rst;
    cbus_req_t  ireq;
    cbus_resp_t iresp;
    cbus_req_t  dreq;
    cbus_resp_t dresp;
    cbus_req_t  oreq;
    cbus_resp_t oresp;
    logic [1:0] owner;

    int checks;
    int failures;

    cbus_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .ireq  (ireq),
        .iresp (iresp),
        .dreq  (dreq),
        .dresp (dresp),
        .oreq  (oreq),
        .oresp (oresp),
        .owner (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic cbus_req_t mk_req(input logic v, input logic w,
                                         input logic [31:0] a, input logic [31:0] d);
        cbus_req_t r;
        r.valid = v;
        r.write = w;
        r.addr  = a;
        r.wdata = d;
        return r;
    endfunction

    function automatic cbus_resp_t mk_resp(input logic rdy, input logic lst,
                                           input logic [31:0] d);
        cbus_resp_t r;
        r.ready = rdy;
        r.last  = lst;
        r.data  = d;
        return r;
    endfunction

    task automatic check(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0]  exp_order [6];
    logic [31:0] exp_addr;

    initial begin
        checks   = 0;
        failures = 0;
        exp_order = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd2};

        // Reset state, with a request already present
        rst   = 1'b1;
        ireq  = mk_req(1'b1, 1'b0, 32'h8000_0000, 32'h0);
        dreq  = '0;
        oresp = mk_resp(1'b1, 1'b1, 32'h1234_5678);
        #3;
        check("rst_owner", 70'(owner), 70'(0));
        check("rst_oreq", 70'(oreq), 70'(0));
        check("rst_iresp", 70'(iresp), 70'(0));
        check("rst_dresp", 70'(dresp), 70'(0));
        ireq  = '0;
        oresp = '0;
        tick();
        tick();
        rst = 1'b0;

        // Single fetch: grant at cycle 1, completion at cycle 5, IDLE at cycle 6
        ireq = mk_req(1'b1, 1'b0, 32'h8000_0000, 32'h0);
        #1;
        check("a_c0_owner", 70'(owner), 70'(0));
        check("a_c0_oreq_vld", 70'(oreq.valid), 70'(0));
        tick();
        check("a_c1_owner", 70'(owner), 70'(1));
        check("a_c1_oreq", 70'(oreq), 70'(mk_req(1'b1, 1'b0, 32'h8000_0000, 32'h0)));
        tick();
        tick();
        tick();
        check("a_c4_owner", 70'(owner), 70'(1));
        tick();
        oresp = mk_resp(1'b1, 1'b1, 32'hDEAD_BEEF);
        #1;
        check("a_c5_owner", 70'(owner), 70'(1));
        check("a_c5_iresp", 70'(iresp), 70'(mk_resp(1'b1, 1'b1, 32'hDEAD_BEEF)));
        check("a_c5_dresp", 70'(dresp), 70'(0));
        ireq = '0;
        tick();
        oresp = '0;
        #1;
        check("a_c6_owner", 70'(owner), 70'(0));
        check("a_c6_oreq_vld", 70'(oreq.valid), 70'(0));

        // Simultaneous requests: data first, one idle cycle, then fetch
        ireq = mk_req(1'b1, 1'b0, 32'h0000_1000, 32'h0);
        dreq = mk_req(1'b1, 1'b1, 32'h0000_2000, 32'h0000_0055);
        tick();
        check("b_gnt_d_owner", 70'(owner), 70'(2));
        check("b_gnt_d_oreq", 70'(oreq), 70'(mk_req(1'b1, 1'b1, 32'h0000_2000, 32'h0000_0055)));
        oresp = mk_resp(1'b1, 1'b1, 32'h0000_00D1);
        #1;
        check("b_dresp", 70'(dresp), 70'(mk_resp(1'b1, 1'b1, 32'h0000_00D1)));
        check("b_iresp_zero", 70'(iresp), 70'(0));
        tick();
        oresp = '0;
        #1;
        check("b_idle_owner", 70'(owner), 70'(0));
        check("b_idle_oreq_vld", 70'(oreq.valid), 70'(0));
        dreq = '0;
        tick();
        check("b_gnt_i_owner", 70'(owner), 70'(1));
        check("b_gnt_i_addr", 70'(oreq.addr), 70'(32'h0000_1000));
        oresp = mk_resp(1'b1, 1'b1, 32'h0);
        tick();
        oresp = '0;
        ireq  = '0;
        #1;
        check("b_end_owner", 70'(owner), 70'(0));

        // Both held: D,D,D,D,I,D with STARVE_LIMIT=4
        ireq = mk_req(1'b1, 1'b0, 32'h0000_7000, 32'h0);
        dreq = mk_req(1'b1, 1'b1, 32'h0000_7100, 32'h0000_0009);
        for (int i = 0; i < 6; i++) begin
            tick();
            exp_addr = (exp_order[i] == 2'd1) ? 32'h0000_7000 : 32'h0000_7100;
            check($sformatf("c_grant%0d_owner", i), 70'(owner), 70'(exp_order[i]));
            check($sformatf("c_grant%0d_addr", i), 70'(oreq.addr), 70'(exp_addr));
            oresp = mk_resp(1'b1, 1'b1, 32'(i));
            tick();
            oresp = '0;
            #1;
            check($sformatf("c_idle%0d_owner", i), 70'(owner), 70'(0));
        end
        ireq = '0;
        dreq = '0;
        tick();

        // Data arrives during a fetch grant; fetch valid drops mid-grant
        ireq = mk_req(1'b1, 1'b0, 32'h0000_3000, 32'h0);
        tick();
        check("d_gnt_i_owner", 70'(owner), 70'(1));
        dreq  = mk_req(1'b1, 1'b1, 32'h0000_4000, 32'h0000_0005);
        oresp = mk_resp(1'b1, 1'b0, 32'h0000_0011);
        #1;
        check("d_dresp_zero", 70'(dresp), 70'(0));
        check("d_oreq_addr", 70'(oreq.addr), 70'(32'h0000_3000));
        check("d_iresp_beat", 70'(iresp), 70'(mk_resp(1'b1, 1'b0, 32'h0000_0011)));
        tick();
        check("d_ready_nolast_owner", 70'(owner), 70'(1));
        ireq.valid = 1'b0;
        #1;
        check("d_drop_oreq_vld", 70'(oreq.valid), 70'(0));
        check("d_drop_oreq_addr", 70'(oreq.addr), 70'(32'h0000_3000));
        check("d_drop_owner", 70'(owner), 70'(1));
        tick();
        check("d_hold_owner", 70'(owner), 70'(1));
        oresp = mk_resp(1'b1, 1'b1, 32'h0000_0012);
        #1;
        check("d_last_iresp", 70'(iresp), 70'(mk_resp(1'b1, 1'b1, 32'h0000_0012)));
        check("d_last_dresp_zero", 70'(dresp), 70'(0));
        tick();
        oresp = '0;
        #1;
        check("d_idle_owner", 70'(owner), 70'(0));
        tick();
        check("d_gnt_d_owner", 70'(owner), 70'(2));
        check("d_gnt_d_oreq", 70'(oreq), 70'(mk_req(1'b1, 1'b1, 32'h0000_4000, 32'h0000_0005)));

        // Reset pulsed during a data grant with a fetch pending
        ireq = mk_req(1'b1, 1'b0, 32'h0000_5000, 32'h0);
        tick();
        check("e_still_d_owner", 70'(owner), 70'(2));
        oresp = mk_resp(1'b1, 1'b0, 32'h0000_0077);
        #1;
        check("e_pre_dresp", 70'(dresp.data), 70'(32'h0000_0077));
        rst = 1'b1;
        #1;
        check("e_rst_owner", 70'(owner), 70'(0));
        check("e_rst_oreq_vld", 70'(oreq.valid), 70'(0));
        check("e_rst_dresp", 70'(dresp), 70'(0));
        dreq  = '0;
        oresp = '0;
        tick();
        rst = 1'b0;
        #1;
        check("e_post_rst_owner", 70'(owner), 70'(0));
        tick();
        check("e_gnt_i_owner", 70'(owner), 70'(1));
        check("e_gnt_i_addr", 70'(oreq.addr), 70'(32'h0000_5000));
        oresp = mk_resp(1'b1, 1'b1, 32'h0);
        tick();
        oresp = '0;
        ireq  = '0;
        #1;
        check("e_end_owner", 70'(owner), 70'(0));

        // Four-beat data burst: three ready-only beats, then last
        dreq = mk_req(1'b1, 1'b0, 32'h0000_6000, 32'h0);
        tick();
        check("f_gnt_d_owner", 70'(owner), 70'(2));
        for (int b = 0; b < 4; b++) begin
            oresp = mk_resp(1'b1, (b == 3), 32'hA0 + 32'(b));
            #1;
            check($sformatf("f_beat%0d_dresp", b), 70'(dresp),
                  70'(mk_resp(1'b1, (b == 3), 32'hA0 + 32'(b))));
            check($sformatf("f_beat%0d_iresp", b), 70'(iresp), 70'(0));
            if (b == 3) dreq = '0;
            tick();
            oresp = '0;
            #1;
            check($sformatf("f_beat%0d_owner_after", b), 70'(owner), 70'((b == 3) ? 0 : 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
